// File: rtl/wfm_table_loader.sv
`default_nettype none
// ============================================================================
// Module      : wfm_table_loader
// Description : Writer-side loader for the DDS waveform-table BRAM port.
//               Accepts one frame of DEPTH samples over valid/ready, writes
//               them to addresses 0..DEPTH-1 one cycle after each transfer,
//               and flags short, long and aborted frames on a sticky err.
//               Optional build macro WFM_TABLE_LOADER_CHECKSUM_EN adds a
//               modulo-2^OW checksum of the samples written.
// Revision    : 1.0 - initial release
// ============================================================================
module wfm_table_loader #(
   parameter int DEPTH = 1024,
   parameter int OW    = 24,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          abort,
   input  logic [OW-1:0] s_data,
   input  logic          s_valid,
   input  logic          s_last,
   output logic          s_ready,
   output logic          wfm_wea,
   output logic [AW-1:0] wfm_waddr,
   output logic [OW-1:0] wfm_din,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [AW:0]   count
`ifdef WFM_TABLE_LOADER_CHECKSUM_EN
   ,
   output logic [OW-1:0] checksum
`endif
);

   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
   localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [AW:0]   count_q, count_d;
   logic          err_q, err_d;
   logic          wea_q, wea_d;
   logic [AW-1:0] waddr_q, waddr_d;
   logic [OW-1:0] din_q, din_d;
   logic          ready_q, ready_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
`ifdef WFM_TABLE_LOADER_CHECKSUM_EN
   logic [OW-1:0] cks_q, cks_d;
`endif

   logic          w_xfer;

   assign w_xfer = s_valid && ready_q;

   // Next-state, write-port and status decode; abort beats a same-edge transfer.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      count_d = count_q;
      err_d   = err_q;
      wea_d   = 1'b0;
      waddr_d = waddr_q;
      din_d   = din_q;
`ifdef WFM_TABLE_LOADER_CHECKSUM_EN
      cks_d   = cks_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_LOAD;
               addr_d  = '0;
               count_d = '0;
               err_d   = 1'b0;
`ifdef WFM_TABLE_LOADER_CHECKSUM_EN
               cks_d   = '0;
`endif
            end
         end
         ST_LOAD: begin
            if (abort) begin
               state_d = ST_DONE;
               err_d   = 1'b1;
            end else if (w_xfer) begin
               wea_d   = 1'b1;
               waddr_d = addr_q;
               din_d   = s_data;
               if (count_q != FULL_CNT) begin
                  count_d = count_q + 1'b1;
               end
`ifdef WFM_TABLE_LOADER_CHECKSUM_EN
               cks_d   = cks_q + s_data;
`endif
               if (addr_q == LAST_ADDR) begin
                  // Table full: a missing s_last means the frame is long.
                  state_d = s_last ? ST_DONE : ST_DRAIN;
                  err_d   = err_q | ~s_last;
               end else begin
                  addr_d = addr_q + 1'b1;
                  if (s_last) begin
                     state_d = ST_DONE;
                     err_d   = 1'b1;
                  end
               end
            end
         end
         ST_DRAIN: begin
            if (abort) begin
               state_d = ST_DONE;
               err_d   = 1'b1;
            end else if (w_xfer && s_last) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      ready_d = (state_d == ST_LOAD) || (state_d == ST_DRAIN);
      busy_d  = ready_d;
      done_d  = (state_d == ST_DONE);
   end

   // State and registered outputs, cleared asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         count_q <= '0;
         err_q   <= 1'b0;
         wea_q   <= 1'b0;
         waddr_q <= '0;
         din_q   <= '0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef WFM_TABLE_LOADER_CHECKSUM_EN
         cks_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         count_q <= count_d;
         err_q   <= err_d;
         wea_q   <= wea_d;
         waddr_q <= waddr_d;
         din_q   <= din_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef WFM_TABLE_LOADER_CHECKSUM_EN
         cks_q   <= cks_d;
`endif
      end
   end

   assign s_ready   = ready_q;
   assign wfm_wea   = wea_q;
   assign wfm_waddr = waddr_q;
   assign wfm_din   = din_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign count     = count_q;
`ifdef WFM_TABLE_LOADER_CHECKSUM_EN
   assign checksum  = cks_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wfm_table_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_wfm_table_loader
// Description : Self-checking bench for wfm_table_loader (DEPTH=8, OW=24):
//               table-driven frames, hand-written reset/abort sequences and
//               randomized frames against a frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wfm_table_loader;

   localparam int DEPTH = 8;
   localparam int OW    = 24;
   localparam int AW    = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          abort;
   logic [OW-1:0] s_data;
   logic          s_valid;
   logic          s_last;
   logic          s_ready;
   logic          wfm_wea;
   logic [AW-1:0] wfm_waddr;
   logic [OW-1:0] wfm_din;
   logic          busy;
   logic          done;
   logic          err;
   logic [AW:0]   count;
`ifdef WFM_TABLE_LOADER_CHECKSUM_EN
   logic [OW-1:0] checksum;
`endif

   int n_checks = 0;
   int n_errors = 0;

   wfm_table_loader #(.DEPTH(DEPTH), .OW(OW)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .abort     (abort),
      .s_data    (s_data),
      .s_valid   (s_valid),
      .s_last    (s_last),
      .s_ready   (s_ready),
      .wfm_wea   (wfm_wea),
      .wfm_waddr (wfm_waddr),
      .wfm_din   (wfm_din),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .count     (count)
`ifdef WFM_TABLE_LOADER_CHECKSUM_EN
      ,
      .checksum  (checksum)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // One frame: frame length (s_last on sample nlast), abort after abort_at
   // transfers (-1 = never), optional valid gaps, a start pulse mid-load and
   // abort raised together with the initial start.
   typedef struct {
      int nlast;
      int abort_at;
      bit gaps;
      bit start_mid;
      bit start_abort;
      bit ramp;
      int exp_count;
      bit exp_err;
   } vec_t;

   task automatic run_frame(input vec_t v, input string tag);
      logic [OW-1:0] smp[$];
      logic [OW-1:0] sum;
      int            sent;
      int            cyc;
      bit            fin;
      bit            val;
      bit            ab;
      bit            rdy;
      for (int i = 0; i < v.nlast; i++) begin
         smp.push_back(v.ramp ? OW'(i + 1) : OW'($urandom));
      end
      start = 1'b1;
      abort = v.start_abort;
      @(posedge clk); #1;
      start = 1'b0;
      abort = 1'b0;
      chk({tag, " err cleared by start"}, 32'(err), 32'd0);
      sum  = '0;
      sent = 0;
      cyc  = 0;
      fin  = 1'b0;
      while (!fin) begin
         val = v.gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
         ab  = (v.abort_at >= 0) && (sent == v.abort_at);
         if (ab) val = 1'b1;
         s_valid = val;
         s_data  = smp[sent];
         s_last  = (sent == v.nlast - 1);
         abort   = ab;
         start   = v.start_mid && (cyc == 2);
         rdy     = s_ready;
         chk({tag, " s_ready in load"}, 32'(rdy), 32'd1);
         chk({tag, " busy in load"}, 32'(busy), 32'd1);
         @(posedge clk); #1;
         s_valid = 1'b0;
         s_last  = 1'b0;
         abort   = 1'b0;
         start   = 1'b0;
         if (!rdy) begin
            fin = 1'b1;
         end else if (ab) begin
            chk({tag, " no write on abort"}, 32'(wfm_wea), 32'd0);
            fin = 1'b1;
         end else if (val) begin
            if (sent < DEPTH) begin
               chk({tag, " wea after xfer"}, 32'(wfm_wea), 32'd1);
               chk({tag, " waddr"}, 32'(wfm_waddr), 32'(sent));
               chk({tag, " din"}, 32'(wfm_din), 32'(smp[sent]));
               sum = sum + smp[sent];
            end else begin
               chk({tag, " no write in drain"}, 32'(wfm_wea), 32'd0);
            end
            sent++;
            if (sent == v.nlast) fin = 1'b1;
         end else begin
            chk({tag, " no write without xfer"}, 32'(wfm_wea), 32'd0);
         end
         cyc++;
         if (cyc > 200) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s timeout: got %0d transfers expected %0d", tag, sent, v.nlast);
            fin = 1'b1;
         end
      end
      chk({tag, " done pulse"}, 32'(done), 32'd1);
      chk({tag, " busy in done"}, 32'(busy), 32'd0);
      chk({tag, " s_ready in done"}, 32'(s_ready), 32'd0);
      chk({tag, " err"}, 32'(err), 32'(v.exp_err));
      chk({tag, " count"}, 32'(count), 32'(v.exp_count));
`ifdef WFM_TABLE_LOADER_CHECKSUM_EN
      chk({tag, " checksum"}, 32'(checksum), 32'(sum));
`endif
      @(posedge clk); #1;
      chk({tag, " done one cycle"}, 32'(done), 32'd0);
      chk({tag, " idle no write"}, 32'(wfm_wea), 32'd0);
      chk({tag, " err sticky"}, 32'(err), 32'(v.exp_err));
      @(posedge clk); #1;
   endtask

   // Frame-level reference: the frame ends at s_last or at the abort; the
   // first DEPTH accepted samples are written; any other length is an error.
   function automatic vec_t model(input int nlast, input int abort_at);
      vec_t r;
      int   k;
      r.nlast    = nlast;
      r.abort_at = abort_at;
      if (abort_at >= 0 && abort_at < nlast) begin
         k         = abort_at;
         r.exp_err = 1'b1;
      end else begin
         k         = nlast;
         r.exp_err = (nlast != DEPTH);
      end
      r.exp_count   = (k < DEPTH) ? k : DEPTH;
      r.gaps        = 1'b0;
      r.start_mid   = 1'b0;
      r.start_abort = 1'b0;
      r.ramp        = 1'b0;
      return r;
   endfunction

   vec_t tbl[9];

   initial begin
      //           nlast abort gaps smid sabt ramp cnt err
      tbl[0] = '{8,  -1, 1'b0, 1'b0, 1'b0, 1'b1, 8, 1'b0};  // exact ramp
      tbl[1] = '{8,  -1, 1'b1, 1'b0, 1'b0, 1'b0, 8, 1'b0};  // gaps
      tbl[2] = '{5,  -1, 1'b0, 1'b0, 1'b0, 1'b1, 5, 1'b1};  // short
      tbl[3] = '{11, -1, 1'b1, 1'b0, 1'b0, 1'b0, 8, 1'b1};  // long
      tbl[4] = '{6,   3, 1'b0, 1'b1, 1'b0, 1'b0, 3, 1'b1};  // abort, ignored start
      tbl[5] = '{8,  -1, 1'b0, 1'b1, 1'b1, 1'b0, 8, 1'b0};  // start wins over abort
      tbl[6] = '{1,  -1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b1};  // single sample
      tbl[7] = '{12,  9, 1'b0, 1'b0, 1'b0, 1'b0, 8, 1'b1};  // abort in drain
      tbl[8] = '{7,  -1, 1'b1, 1'b0, 1'b0, 1'b0, 7, 1'b1};  // short by one

      rst     = 1'b1;
      start   = 1'b0;
      abort   = 1'b0;
      s_data  = '0;
      s_valid = 1'b0;
      s_last  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset s_ready", 32'(s_ready), 32'd0);
      chk("reset wea", 32'(wfm_wea), 32'd0);
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset done", 32'(done), 32'd0);
      chk("reset err", 32'(err), 32'd0);
      chk("reset count", 32'(count), 32'd0);
      chk("reset waddr", 32'(wfm_waddr), 32'd0);
      chk("reset din", 32'(wfm_din), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 9; i++) begin
         run_frame(tbl[i], $sformatf("vec%0d", i));
      end

      // abort in IDLE after an errored frame: no done, err untouched
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      chk("idle abort done", 32'(done), 32'd0);
      chk("idle abort busy", 32'(busy), 32'd0);
      chk("idle abort err", 32'(err), 32'd1);
      @(posedge clk); #1;

      // asynchronous reset after four transfers
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         s_valid = 1'b1;
         s_data  = OW'(32'h100 + i);
         @(posedge clk); #1;
      end
      s_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk("async rst wea", 32'(wfm_wea), 32'd0);
      chk("async rst busy", 32'(busy), 32'd0);
      chk("async rst s_ready", 32'(s_ready), 32'd0);
      chk("async rst count", 32'(count), 32'd0);
      chk("async rst waddr", 32'(wfm_waddr), 32'd0);
      chk("async rst din", 32'(wfm_din), 32'd0);
      chk("async rst err", 32'(err), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      run_frame(tbl[0], "after rst");

      // randomized frames against the frame-level model
      for (int i = 0; i < 25; i++) begin
         vec_t rv;
         int   nl;
         int   aa;
         nl = int'($urandom_range(1, 12));
         aa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, nl - 1)) : -1;
         rv = model(nl, aa);
         rv.gaps        = ($urandom_range(0, 1) == 1);
         rv.start_mid   = ($urandom_range(0, 3) == 0);
         rv.start_abort = ($urandom_range(0, 3) == 0);
         run_frame(rv, $sformatf("rnd%0d", i));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/wfm_table_loader.md
Name: wfm_table_loader

Overview:
- Writer-side companion to the DDS waveform-table BRAM write port.
- Accepts a stream of samples over a valid/ready handshake and drives wfm_wea/wfm_waddr/wfm_din to load one full table at run time.
- Enforces frame length equal to DEPTH and flags short or long frames.
- Asserts busy while loading so the system can gate the DDS clock enable during table updates.

Parameters:
- DEPTH, 1024: number of table entries; must match the target DDS.
- OW, 24: sample width; must match the DDS output width.
- AW, $clog2(DEPTH): table address width; derived, not overridden.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to begin a table load; honoured only in IDLE.
- abort  in  1  cancels a load in progress.
- s_data  in  OW  sample input.
- s_valid  in  1  s_data is valid.
- s_last  in  1  marks the final sample of the frame.
- s_ready  out  1  loader accepts a sample this cycle.
- wfm_wea  out  1  table write enable, to the DDS.
- wfm_waddr  out  AW  table write address, to the DDS.
- wfm_din  out  OW  table write data, to the DDS.
- busy  out  1  high in LOAD and DRAIN.
- done  out  1  one-cycle pulse when a load ends for any reason.
- err  out  1  sticky error flag; cleared on an accepted start.
- count  out  AW+1  number of samples written in the current or last load.

Behaviour:
- Reset values (asynchronous): state IDLE; s_ready, wfm_wea, busy, done, err all 0; wfm_waddr, wfm_din, count all 0.
- Handshake:
  - A sample transfers on a rising edge where s_valid and s_ready are both 1.
  - s_ready is registered and depends only on state: 1 in LOAD and DRAIN, 0 otherwise.
- IDLE:
  - start=1 moves to LOAD.
  - Same edge: address counter to 0, count to 0, err to 0.
- LOAD, on each transfer:
  - Next cycle: wfm_wea=1, wfm_waddr=addr, wfm_din=s_data. Latency is 1 cycle from transfer to write.
  - addr increments and count increments.
  - wfm_wea=0 on every cycle without a transfer.
- LOAD exit conditions:
  - Transfer with addr==DEPTH-1 and s_last=1: go to DONE, err stays 0.
  - Transfer with addr==DEPTH-1 and s_last=0: the sample is written, then go to DRAIN and set err (long frame).
  - Transfer with s_last=1 and addr<DEPTH-1: the sample is written, then go to DONE and set err (short frame). Entries above addr keep their previous contents.
- DRAIN:
  - Accepts and discards samples with no writes.
  - A transfer with s_last=1 moves to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. s_ready=0.
- abort=1 in LOAD or DRAIN:
  - Moves to DONE and sets err.
  - Any transfer on that same edge is discarded.
  - abort has no effect in IDLE or DONE.
- start outside IDLE is ignored; start and abort together in IDLE → start wins.
- Address never wraps; no write is issued at an address ≥ DEPTH.
- count saturates at DEPTH.
- Asynchronous rst mid-load returns everything to reset values. Partial table contents stay as written; no error is reported.

Optional Feature:
- Macro: WFM_TABLE_LOADER_CHECKSUM_EN.
- Defined:
  - Adds output port checksum [OW-1:0]: the modulo-2^OW sum of every sample written to the table during the current or last load.
  - Cleared on an accepted start and on rst.
  - Updates on the cycle wfm_wea is asserted.
  - Discarded DRAIN samples are excluded.
- Undefined: the port and adder are absent; all other behaviour is identical.

Test Plan (DEPTH=8, OW=24):
- Exact load: start, then 8 samples 0x000001..0x000008 with s_last on the 8th → writes to addr 0..7 one cycle after each transfer; done pulses once; err=0; count=8; checksum=0x000024 when enabled.
- Backpressure and gaps: s_valid toggling 1/0 over the 8 samples → wfm_wea is asserted only on cycles following transfers; addresses remain contiguous 0..7.
- Short frame: s_last on the 5th sample → 5 writes to addr 0..4; done; err=1; count=5; addr 5..7 are not written.
- Long frame: 11 samples with s_last on the 11th → 8 writes; samples 9..11 are accepted with wfm_wea=0; done one cycle after the 11th transfer; err=1; count=8.
- Abort and ignored start: abort after 3 transfers → done, err=1, no further writes; start pulsed during LOAD → no restart, addresses continue.
- Asynchronous reset mid-load: assert rst between clock edges after 4 transfers → outputs zero immediately; after release, a new start loads from addr 0 with err=0.
